// File: rtl/pc_unit_if.sv
// Bundle of the PC unit's control, redirect-target and status signals.
// The core drives the slave side; the master side belongs to the surrounding pipeline.
interface pc_unit_if #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 i_enable;
  logic                 i_step_mode;
  logic                 i_step;
  logic                 i_pc_write;
  logic                 i_branch_taken;
  logic [PC_WIDTH-1:0]  i_branch_target;
  logic                 i_jump;
  logic [PC_WIDTH-1:0]  i_jump_target;
  logic                 i_jump_reg;
  logic [PC_WIDTH-1:0]  i_jr_target;
  logic                 i_halt;
  logic [PC_WIDTH-1:0]  o_pc;
  logic [PC_WIDTH-1:0]  o_pc_plus4;
  logic                 o_halted;
  logic                 o_misaligned;
  logic [CNT_WIDTH-1:0] o_fetch_count;

  modport slave (
    input  i_enable, i_step_mode, i_step, i_pc_write,
           i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_jump_reg, i_jr_target, i_halt,
    output o_pc, o_pc_plus4, o_halted, o_misaligned, o_fetch_count
  );

  modport master (
    output i_enable, i_step_mode, i_step, i_pc_write,
           i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_jump_reg, i_jr_target, i_halt,
    input  o_pc, o_pc_plus4, o_halted, o_misaligned, o_fetch_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised redirects, stall/step gating, halt and
// misaligned-target trapping, plus a saturating fetch counter.
module pc_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned          CNT_WIDTH    = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  pc_unit_if.slave    bus
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 misaligned_q, misaligned_d;
  logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic [PC_WIDTH-1:0]  pc_plus4;
  logic [PC_WIDTH-1:0]  next_pc;
  logic                 redirect;
  logic                 halt_req;
  logic                 advance;
  logic                 bad_target;
  logic                 load_pc;

  always_comb begin
    pc_plus4 = pc_q + PC_WIDTH'(4);

    redirect = 1'b1;
    if (bus.i_jump_reg)          next_pc = bus.i_jr_target;
    else if (bus.i_jump)         next_pc = bus.i_jump_target;
    else if (bus.i_branch_taken) next_pc = bus.i_branch_target;
    else begin
      next_pc  = pc_plus4;
      redirect = 1'b0;
    end

    // A halt request wins over any same-cycle advance, so it masks advance here.
    halt_req   = (state_q == RUN) && bus.i_enable && bus.i_halt;
    advance    = (state_q == RUN) && bus.i_enable && bus.i_pc_write &&
                 (!bus.i_step_mode || bus.i_step) && !halt_req;
    bad_target = advance && redirect && (next_pc[1:0] != 2'b00);
    load_pc    = advance && !bad_target;

    state_d       = state_q;
    pc_d          = pc_q;
    misaligned_d  = misaligned_q || bad_target;
    fetch_count_d = fetch_count_q;

    if (halt_req || bad_target) state_d = HALTED;
    if (load_pc) begin
      pc_d = next_pc;
      if (fetch_count_q != '1) fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_pc_plus4    = pc_plus4;
  assign bus.o_halted      = (state_q == HALTED);
  assign bus.o_misaligned  = misaligned_q;
  assign bus.o_fetch_count = fetch_count_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of program counter and all target buses.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of fetch counter.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_enable  input  1  global run enable from debug unit.
REQ-007 SHALL have port i_step_mode  input  1  1 = advance only on i_step pulses.
REQ-008 SHALL have port i_step  input  1  single-cycle step request, used only in step mode.
REQ-009 SHALL have port i_pc_write  input  1  hazard-unit write permit; 0 = stall.
REQ-010 SHALL have port i_branch_taken  input  1  select i_branch_target.
REQ-011 SHALL have port i_branch_target  input  PC_WIDTH  branch destination.
REQ-012 SHALL have port i_jump  input  1  select i_jump_target.
REQ-013 SHALL have port i_jump_target  input  PC_WIDTH  J/JAL destination.
REQ-014 SHALL have port i_jump_reg  input  1  select i_jr_target.
REQ-015 SHALL have port i_jr_target  input  PC_WIDTH  JR/JALR destination.
REQ-016 SHALL have port i_halt  input  1  HALT instruction decoded.
REQ-017 SHALL have port o_pc  output  PC_WIDTH  current PC.
REQ-018 SHALL have port o_pc_plus4  output  PC_WIDTH  o_pc + 4, combinational.
REQ-019 SHALL have port o_halted  output  1  1 while in HALTED state.
REQ-020 SHALL have port o_misaligned  output  1  sticky misaligned-target flag.
REQ-021 SHALL have port o_fetch_count  output  CNT_WIDTH  number of PC advances since reset.

Function
REQ-022 SHALL implement states RUN and HALTED; o_halted = 1 exactly in HALTED.
REQ-023 SHALL define advance = RUN & i_enable & i_pc_write & (~i_step_mode | i_step).
REQ-024 SHALL, on advance, load PC with next_pc, selected by priority i_jump_reg > i_jump > i_branch_taken > o_pc_plus4.
REQ-025 SHALL hold PC unchanged in any cycle without advance.
REQ-026 SHALL compute o_pc_plus4 modulo 2^PC_WIDTH; RESET_VECTOR-relative wrap from all-ones-minus-3 to 0 is legal.
REQ-027 SHALL, on advance with selected redirect target bits [1:0] != 0, keep PC unchanged, set o_misaligned, and enter HALTED next cycle.
REQ-028 SHALL not check alignment of o_pc_plus4.
REQ-029 SHALL, on i_halt = 1 in RUN with i_enable = 1, enter HALTED next cycle without updating PC, regardless of i_pc_write or step gating.
REQ-030 SHALL give i_halt priority over a same-cycle redirect; o_misaligned is not set in that cycle.
REQ-031 SHALL leave HALTED only via reset.
REQ-032 SHALL increment o_fetch_count by 1 per cycle in which PC is loaded; saturate at all-ones.
REQ-033 SHALL, in step mode, advance at most once per i_step cycle; an i_step held high for N cycles gives N advances.
REQ-034 SHALL ignore i_step when i_step_mode = 0.

Reset
REQ-035 SHALL, with i_reset = 1 at a rising edge, set PC = RESET_VECTOR, state = RUN, o_misaligned = 0, o_fetch_count = 0; reset overrides all other inputs including mid-stall and HALTED.
REQ-036 SHALL have no asynchronous behaviour; i_reset between edges has no effect.

Verification
REQ-037 SHALL verify sequential run: reset, i_enable = 1, i_pc_write = 1 for 4 cycles -> o_pc 0,4,8,12,16; o_fetch_count = 4.
REQ-038 SHALL verify priority: i_jump_reg = 1 (0x100), i_jump = 1 (0x200), i_branch_taken = 1 (0x300) same cycle -> o_pc = 0x100.
REQ-039 SHALL verify stall: i_pc_write = 0 for 3 cycles at o_pc = 0x10 -> o_pc stays 0x10, count unchanged; then i_pc_write = 1 -> o_pc = 0x14.
REQ-040 SHALL verify misaligned: i_jump = 1, target 0x202 at o_pc = 0x8 -> o_pc stays 0x8, o_misaligned = 1, o_halted = 1 next cycle.
REQ-041 SHALL verify halt and reset: i_halt at o_pc = 0x20 -> o_halted = 1, o_pc frozen at 0x20 for 5 cycles; i_reset -> o_pc = RESET_VECTOR, o_halted = 0.
REQ-042 SHALL verify step mode: i_step_mode = 1, two single-cycle i_step pulses 3 cycles apart from 0 -> o_pc 0 -> 4 -> 8, unchanged between pulses.
